// File: rtl/bcd_pkg.sv
// ============================================================================
// Module  : bcd_pkg
// Brief   : Shared BCD widths, converter state type and digit-correction consts
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;

  localparam logic [BCD_DIGIT_W-1:0] DIGIT_THRESH = 4'd8;
  localparam logic [BCD_DIGIT_W-1:0] DIGIT_ADJ    = 4'd3;
  localparam logic [BCD_DIGIT_W-1:0] DIGIT_MAX    = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : bcd_pkg

`default_nettype wire

// File: rtl/bcd_digit_adj.sv
// ============================================================================
// Module  : bcd_digit_adj
// Brief   : Reverse double-dabble correction: a digit >= 8 after a shift loses 3
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d_in,
  output logic [BCD_DIGIT_W-1:0] d_out
);

  always_comb begin
    d_out = d_in;
    if (d_in >= DIGIT_THRESH) begin
      d_out = d_in - DIGIT_ADJ;
    end
  end

endmodule : bcd_digit_adj

`default_nettype wire

// File: rtl/bcd2bin.sv
// ============================================================================
// Module  : bcd2bin
// Brief   : Sequential packed-BCD to binary converter, one bit per cycle.
//           Optional invalid-digit check: define BCD2BIN_ERR_CHECK_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd2bin
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 3,
  parameter int BIN_W      = 10
) (
  input  logic                              Clk,
  input  logic                              Rst_n,
  input  logic                              Start,
  input  logic [BCD_DIGIT_W*NUM_DIGITS-1:0] Bcd,
  output logic                              Busy,
  output logic                              Done,
  output logic [BIN_W-1:0]                  Bin,
  output logic                              Err
);

  localparam int BCD_W = BCD_DIGIT_W * NUM_DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  state_t                 state_q, state_d;
  logic [BCD_W-1:0]       bcd_q,   bcd_d;
  logic [BIN_W-1:0]       bin_q,   bin_d;
  logic [CNT_W-1:0]       cnt_q,   cnt_d;
  logic                   busy_q,  busy_d;
  logic                   done_q,  done_d;
  logic [BIN_W-1:0]       res_q,   res_d;

  logic [BCD_W+BIN_W-1:0] w_shift;
  logic [BCD_W-1:0]       w_adj_bcd;
  logic [BIN_W-1:0]       w_shift_bin;

  assign w_shift     = {bcd_q, bin_q} >> 1;
  assign w_shift_bin = w_shift[BIN_W-1:0];

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_in  (w_shift[BIN_W + i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .d_out (w_adj_bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

`ifdef BCD2BIN_ERR_CHECK_EN
  logic                  errlat_q, errlat_d;
  logic                  err_q,    err_d;
  logic [NUM_DIGITS-1:0] w_dig_bad;
  logic                  w_bad;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_chk
    assign w_dig_bad[i] = (Bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W] > DIGIT_MAX);
  end
  assign w_bad = |w_dig_bad;
  assign Err   = err_q;
`else
  assign Err   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    res_d   = res_q;
`ifdef BCD2BIN_ERR_CHECK_EN
    errlat_d = errlat_q;
    err_d    = err_q;
`endif
    case (state_q)
      ITER: begin
        bcd_d = w_adj_bcd;
        bin_d = w_shift_bin;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
`ifdef BCD2BIN_ERR_CHECK_EN
          res_d   = errlat_q ? '0 : w_shift_bin;
          err_d   = errlat_q;
`else
          res_d   = w_shift_bin;
`endif
        end
      end
      default: begin
        // IDLE and DONE both accept a new request; DONE otherwise drops to IDLE
        busy_d = 1'b0;
        if (state_q != IDLE) begin
          state_d = IDLE;
        end
        if (Start) begin
          state_d = ITER;
          busy_d  = 1'b1;
          bcd_d   = Bcd;
          bin_d   = '0;
          cnt_d   = '0;
`ifdef BCD2BIN_ERR_CHECK_EN
          errlat_d = w_bad;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
`ifdef BCD2BIN_ERR_CHECK_EN
      errlat_q <= 1'b0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      res_q   <= res_d;
`ifdef BCD2BIN_ERR_CHECK_EN
      errlat_q <= errlat_d;
      err_q    <= err_d;
`endif
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign Bin  = res_q;

endmodule : bcd2bin

`default_nettype wire

// File: tb/tb_bcd2bin.sv
// ============================================================================
// Module  : tb_bcd2bin
// Brief   : Directed vector table plus multi-cycle corner sequences for bcd2bin
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd2bin;

  localparam int ND  = 3;
  localparam int BW  = 10;
  localparam int LAT = BW;  // ticks from accept edge to Done visible

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic          Start = 1'b0;
  logic [4*ND-1:0] Bcd = '0;
  logic          Busy, Done, Err;
  logic [BW-1:0] Bin;

  int total = 0;
  int bad   = 0;

  bcd2bin #(.NUM_DIGITS(ND), .BIN_W(BW)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .Start (Start),
    .Bcd   (Bcd),
    .Busy  (Busy),
    .Done  (Done),
    .Bin   (Bin),
    .Err   (Err)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [11:0] bcd;
    logic [9:0]  bin;
  } vec_t;

  vec_t vecs [12];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!Done && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic conv(input logic [11:0] b, input logic [9:0] exp_bin,
                      input logic exp_err, input string name);
    int n;
    Bcd   = b;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk({name, "_busy"}, 32'(Busy), 32'd1);
    wait_done(n);
    chk({name, "_lat"}, 32'(n), 32'(LAT));
    chk({name, "_bin"}, 32'(Bin), 32'(exp_bin));
    chk({name, "_err"}, 32'(Err), 32'(exp_err));
    chk({name, "_busy_done"}, 32'(Busy), 32'd0);
    tick();
    chk({name, "_done_pulse"}, 32'(Done), 32'd0);
  endtask

  task automatic no_done(input int cycles, input string name);
    int seen = 0;
    for (int k = 0; k < cycles; k++) begin
      tick();
      if (Done) seen++;
    end
    chk(name, 32'(seen), 32'd0);
  endtask

  initial begin
    int n;
    logic [9:0] held;

    vecs[0]  = '{12'h999, 10'd999};
    vecs[1]  = '{12'h000, 10'd0};
    vecs[2]  = '{12'h905, 10'd905};
    vecs[3]  = '{12'h001, 10'd1};
    vecs[4]  = '{12'h010, 10'd10};
    vecs[5]  = '{12'h100, 10'd100};
    vecs[6]  = '{12'h512, 10'd512};
    vecs[7]  = '{12'h511, 10'd511};
    vecs[8]  = '{12'h250, 10'd250};
    vecs[9]  = '{12'h088, 10'd88};
    vecs[10] = '{12'h767, 10'd767};
    vecs[11] = '{12'h042, 10'd42};

    Rst_n = 1'b0;
    tick(); tick();
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_bin",  32'(Bin),  32'd0);
    chk("rst_err",  32'(Err),  32'd0);
    Rst_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      conv(vecs[i].bcd, vecs[i].bin, 1'b0, $sformatf("vec%0d", i));
    end

    // Result holds with Start low
    conv(12'h905, 10'd905, 1'b0, "hold_load");
    held = Bin;
    no_done(8, "hold_no_done");
    chk("hold_bin", 32'(Bin), 32'd905);
    chk("hold_vs_prev", 32'(Bin), 32'(held));

    // Back-to-back: Start held through DONE
    Bcd = 12'h123; Start = 1'b1;
    tick();
    Bcd = 12'h456;
    wait_done(n);
    chk("b2b_lat1", 32'(n), 32'(LAT));
    chk("b2b_bin1", 32'(Bin), 32'd123);
    tick();
    Start = 1'b0;
    chk("b2b_busy", 32'(Busy), 32'd1);
    wait_done(n);
    chk("b2b_gap", 32'(n + 1), 32'(LAT + 1));
    chk("b2b_bin2", 32'(Bin), 32'd456);
    no_done(15, "b2b_no_third");

    // Start re-pulsed mid-conversion is ignored
    Bcd = 12'h321; Start = 1'b1;
    tick();
    Start = 1'b0;
    tick(); tick(); tick();
    Bcd = 12'h111; Start = 1'b1;
    tick();
    Start = 1'b0;
    n = 0;
    while (!Done && n < 40) begin
      tick();
      n++;
    end
    chk("repulse_lat", 32'(n + 4), 32'(LAT));
    chk("repulse_bin", 32'(Bin), 32'd321);
    no_done(15, "repulse_single");

    // Reset mid-conversion aborts
    Bcd = 12'h777; Start = 1'b1;
    tick();
    Start = 1'b0;
    tick(); tick();
    Rst_n = 1'b0; Start = 1'b1;
    tick();
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_done", 32'(Done), 32'd0);
    chk("abort_bin",  32'(Bin),  32'd0);
    chk("abort_err",  32'(Err),  32'd0);
    tick();
    Rst_n = 1'b1; Start = 1'b0;
    no_done(15, "abort_no_done");
    chk("abort_bin_after", 32'(Bin), 32'd0);
    conv(12'h042, 10'd42, 1'b0, "after_abort");

    // Invalid digit
`ifdef BCD2BIN_ERR_CHECK_EN
    conv(12'h9A0, 10'd0, 1'b1, "errdig");
    conv(12'h123, 10'd123, 1'b0, "err_clear");
`else
    begin
      int errs = 0;
      Bcd = 12'h9A0; Start = 1'b1;
      tick();
      Start = 1'b0;
      for (int k = 0; k < 15; k++) begin
        if (Err) errs++;
        tick();
      end
      chk("noerr_const", 32'(errs), 32'd0);
    end
    conv(12'h123, 10'd123, 1'b0, "noerr_next");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_bcd2bin

`default_nettype wire
